// File: rtl/as_arbiter.sv
// -----------------------------------------------------------------------------
// as_arbiter
// Round-robin arbiter/sequencer that shares one add/sub datapath among
// NUM_REQ requesters. One operation is in flight at a time:
//   IDLE -> grant a requester, register its operands towards the datapath
//   WAIT -> hold operands for AS_LATENCY+1 cycles, then capture as_result
//   RESP -> present the result with the requester id until rsp_ready
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot, IDLE only)
//   req_a/req_b/req_op      per-requester operands (slice i) and opcode bit i
//   as_a_in/as_b_in/as_opcode  registered operands/opcode to the datapath
//   as_result               datapath result (DATA_WIDTH+1 bits)
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_result       id of the issuing requester and captured result
//   busy                    high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module as_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int AS_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ-1:0]             req_op,
    output logic [DATA_WIDTH-1:0]          as_a_in,
    output logic [DATA_WIDTH-1:0]          as_b_in,
    output logic                           as_opcode,
    input  logic [DATA_WIDTH:0]            as_result,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH:0]            rsp_result,
    output logic                           busy
);

    localparam int CNT_W = (AS_LATENCY > 0) ? $clog2(AS_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ID_WIDTH-1:0]    r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0]  r_as_a_in;
    logic [DATA_WIDTH-1:0]  r_as_b_in;
    logic                   r_as_opcode;
    logic                   r_rsp_valid;
    logic [ID_WIDTH-1:0]    r_rsp_id;
    logic [DATA_WIDTH:0]    r_rsp_result;
    logic                   r_busy;

    logic                   w_any;
    logic                   w_hit;
    logic [ID_WIDTH-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0]     w_gnt_oh;
    logic [DATA_WIDTH-1:0]  w_sel_a;
    logic [DATA_WIDTH-1:0]  w_sel_b;
    logic                   w_sel_op;

    // Requester index 'offset' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] f_rr_index(input logic [ID_WIDTH-1:0] base,
                                                       input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_REQ;
        return ID_WIDTH'(sum);
    endfunction

    // Round-robin search: first valid requester starting just after the last grant.
    always_comb begin
        w_any     = 1'b0;
        w_hit     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_hit     = ~w_any & req_valid[f_rr_index(r_ptr, k)];
            w_gnt_idx = w_hit ? f_rr_index(r_ptr, k) : w_gnt_idx;
            w_any     = w_any | w_hit;
        end
    end

    // Decode the winner into a one-hot grant and select its payload.
    always_comb begin
        w_gnt_oh = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == ID_WIDTH'(i)) begin
                w_gnt_oh[i] = w_any;
                w_sel_a     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_op    = req_op[i];
            end else begin
                w_gnt_oh[i] = 1'b0;
            end
        end
    end

    // Grants are only offered in IDLE and never while reset is asserted.
    assign req_ready = {NUM_REQ{(r_state == ST_IDLE) & reset_n}} & w_gnt_oh;

    // Next-state logic for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath-side registers: operand issue, latency count, result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= ID_WIDTH'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_as_a_in    <= '0;
            r_as_b_in    <= '0;
            r_as_opcode  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_as_a_in   <= w_sel_a;
                        r_as_b_in   <= w_sel_b;
                        r_as_opcode <= w_sel_op;
                        r_rsp_id    <= w_gnt_idx;
                        r_ptr       <= w_gnt_idx;
                        r_cnt       <= CNT_W'(AS_LATENCY);
                    end
                end
                ST_WAIT: begin
                    // The counter reaching zero marks the datapath result as settled.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rsp_result <= as_result;
                        r_rsp_valid  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign as_a_in    = r_as_a_in;
    assign as_b_in    = r_as_b_in;
    assign as_opcode  = r_as_opcode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;

endmodule

// File: doc/as_arbiter.md
Name: as_arbiter

Overview:
Round-robin arbiter and sequencer that shares one add/sub datapath (as_inf-style unit: a_in, b_in, opcode, result) among NUM_REQ requesters. Accepts one operation at a time through per-requester valid/ready handshakes and drives the operands and opcode to the datapath. Waits the datapath latency, captures the result and returns it with the requester id over a valid/ready response channel. Sits between client blocks and the single shared add/sub unit.

Parameters:
DATA_WIDTH, 8, operand width (matches `data_width).
NUM_REQ, 4, number of requesters (2..16).
ID_WIDTH, 2, width of rsp_id; must equal clog2(NUM_REQ).
AS_LATENCY, 1, cycles from operands stable at the datapath to result valid (0 = combinational unit).

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  one-hot accept; handshake when valid&ready
req_a  input  NUM_REQ*DATA_WIDTH  operand A, slice i for requester i
req_b  input  NUM_REQ*DATA_WIDTH  operand B, slice i
req_op  input  NUM_REQ  opcode per requester (0 add, 1 sub)
as_a_in  output  DATA_WIDTH  operand A to datapath (registered)
as_b_in  output  DATA_WIDTH  operand B to datapath (registered)
as_opcode  output  1  opcode to datapath (registered)
as_result  input  DATA_WIDTH+1  datapath result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  ID_WIDTH  index of requester that issued the op
rsp_result  output  DATA_WIDTH+1  captured as_result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE; as_a_in=0, as_b_in=0, as_opcode=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, wait counter=0, rr pointer=NUM_REQ-1. req_ready is forced 0 while reset_n=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first set bit searching from (ptr+1) mod NUM_REQ upward with wrap. req_ready is combinational one-hot for g in IDLE only, zero otherwise. On that edge: as_a_in/as_b_in/as_opcode <= slice g, rsp_id <= g, ptr <= g, counter <= AS_LATENCY, state -> WAIT. No valid: stay IDLE, outputs hold.
- WAIT: operands held stable. If counter != 0, decrement. If counter == 0, rsp_result <= as_result, rsp_valid <= 1, state -> RESP. WAIT therefore lasts AS_LATENCY+1 cycles.
- RESP: rsp_valid, rsp_id and rsp_result held stable until rsp_ready=1. On that edge: rsp_valid <= 0, state -> IDLE. No new request is accepted in the same cycle (req_ready=0 in RESP).
- Timing: acceptance at edge E0 -> rsp_valid high after edge E0+AS_LATENCY+1. Minimum issue interval is AS_LATENCY+3 cycles.
- Operands, opcode and result are passed unmodified; no arithmetic in this block. rsp_result width is DATA_WIDTH+1.
- Requesters hold valid and payload until ready. A valid dropped before grant is never granted. Valid on a non-granted requester is ignored until a later IDLE cycle.
- Fairness: after requester g is served, every other waiting requester is granted before g is granted again.
- Reset mid-operation (WAIT or RESP): in-flight op is discarded, no response is emitted, and all outputs return to reset values immediately.
- as_a_in/as_b_in/as_opcode retain the last issued operation after RESP (not cleared).

Test Plan:
- Single op (W=8, N=4, L=1): req 2 valid, a=0x05, b=0x03, op=0 -> req_ready=4'b0100 one cycle. as_a_in=0x05, as_b_in=0x03, as_opcode=0 next cycle. rsp_valid 2 cycles after accept with rsp_id=2 and rsp_result = datapath output 0x008.
- Subtract passthrough: req 0, a=0x03, b=0x05, op=1, model datapath returns 0x1FE -> rsp_result=0x1FE, rsp_id=0, as_opcode=1.
- Contention: all four req_valid high from reset, rsp_ready=1 -> grant order 0,1,2,3,0. Each grant is spaced AS_LATENCY+3=4 cycles apart.
- Fairness wrap: req 3 held valid continuously, req 1 raised after req 3's first grant -> order 3,1,3,1.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable, req_ready=0, busy=1. Release -> IDLE next cycle.
- Reset in WAIT: assert reset_n=0 during WAIT -> rsp_valid=0, busy=0, as_* = 0 immediately, no response. After release with all valid high, req 0 is granted first.
